// File: rtl/hes_pkg.sv
// Shared types and helpers for the cipher arbiter slice.
package hes_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_e;

  // Channel-index width; never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hes_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module hes_rr_arbiter
  import hes_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_CH;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hes_cipher_arbiter.sv
// Message-granular arbiter in front of a single-context byte cipher, with a
// tag pipeline that labels each cipher result with its channel and last flag.
module hes_cipher_arbiter
  import hes_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned CH_W = ch_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_sop,
  input  logic [NUM_CH-1:0]     req_eop,
  input  logic [NUM_CH*8-1:0]   req_key,
  input  logic [NUM_CH*8-1:0]   req_data,
  output logic [NUM_CH-1:0]     req_ready,
  output logic                  c_valid_in,
  output logic                  c_new_message,
  output logic [7:0]            c_key,
  output logic [7:0]            c_data_in,
  input  logic                  c_valid_out,
  input  logic [7:0]            c_data_out,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic [CH_W-1:0]       rsp_ch,
  output logic                  rsp_last,
  output logic                  lock_active,
  output logic [CH_W-1:0]       lock_owner,
  output logic                  abort
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CH_W-1:0]   tag_owner_q, tag_owner_d;
  logic              tag_eop_q, tag_eop_d;
  logic              abort_q, abort_d;

  logic [NUM_CH-1:0] arb_req, arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_valid;
  logic [CH_W-1:0]   cur_ch;
  logic              xfer, cur_sop, cur_eop;
  logic [7:0]        key_arr  [NUM_CH];
  logic [7:0]        data_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign key_arr[g]  = req_key[8*g +: 8];
    assign data_arr[g] = req_data[8*g +: 8];
  end

  function automatic logic [CH_W-1:0] ptr_after(input logic [CH_W-1:0] ch);
    return (32'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;
  endfunction

  // Only message starts compete; mid-message bytes wait for sop.
  assign arb_req = (state_q == IDLE) ? (req_valid & req_sop) : '0;

  hes_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .req         (arb_req),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    req_ready = '0;
    cur_ch    = owner_q;
    xfer      = 1'b0;
    if (state_q == IDLE) begin
      req_ready = arb_grant;
      cur_ch    = arb_idx;
      xfer      = arb_valid;
    end else begin
      req_ready[owner_q] = 1'b1;
      xfer               = req_valid[owner_q];
    end
    cur_sop       = req_sop[cur_ch];
    cur_eop       = req_eop[cur_ch];
    c_valid_in    = xfer;
    c_new_message = xfer & cur_sop;
    c_key         = xfer ? key_arr[cur_ch] : 8'h00;
    c_data_in     = xfer ? data_arr[cur_ch] : 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    idle_cnt_d  = idle_cnt_q;
    tag_owner_d = tag_owner_q;
    tag_eop_d   = tag_eop_q;
    abort_d     = 1'b0;
    if (xfer) begin
      tag_owner_d = cur_ch;
      tag_eop_d   = cur_eop;
    end
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (cur_eop) begin
            rr_ptr_d = ptr_after(cur_ch);
          end else begin
            state_d    = LOCKED;
            owner_d    = cur_ch;
            idle_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (cur_eop) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_after(owner_q);
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          // A stalled owner would otherwise hold the cipher forever.
          if (TIMEOUT != 0 && 32'(idle_cnt_d) == TIMEOUT) begin
            state_d    = IDLE;
            abort_d    = 1'b1;
            rr_ptr_d   = ptr_after(owner_q);
            idle_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      tag_owner_q <= '0;
      tag_eop_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      idle_cnt_q  <= idle_cnt_d;
      tag_owner_q <= tag_owner_d;
      tag_eop_q   <= tag_eop_d;
      abort_q     <= abort_d;
    end
  end

  assign rsp_valid   = c_valid_out;
  assign rsp_data    = c_data_out;
  assign rsp_ch      = tag_owner_q;
  assign rsp_last    = tag_eop_q;
  assign lock_active = (state_q == LOCKED);
  assign lock_owner  = owner_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_hes_cipher_arbiter.sv
// Directed scenarios followed by random traffic, checked against a behavioural
// model of message-level arbitration and a stand-in 1-cycle cipher.
module tb_hes_cipher_arbiter;

  localparam int N = 4;
  localparam int T = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0, req_sop = '0, req_eop = '0;
  logic [N*8-1:0] req_key = '0, req_data = '0;
  logic [N-1:0]  req_ready;
  logic          c_valid_in, c_new_message;
  logic [7:0]    c_key, c_data_in;
  logic          c_valid_out;
  logic [7:0]    c_data_out;
  logic          rsp_valid, rsp_last, lock_active, abort;
  logic [7:0]    rsp_data;
  logic [1:0]    rsp_ch, lock_owner;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_locked, m_abort, m_tag_eop, m_pv;
  int m_owner, m_ptr, m_idle, m_tag_ch;
  logic [7:0] m_pout;

  hes_cipher_arbiter #(
    .NUM_CH  (N),
    .TIMEOUT (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_sop       (req_sop),
    .req_eop       (req_eop),
    .req_key       (req_key),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .c_valid_in    (c_valid_in),
    .c_new_message (c_new_message),
    .c_key         (c_key),
    .c_data_in     (c_data_in),
    .c_valid_out   (c_valid_out),
    .c_data_out    (c_data_out),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ch        (rsp_ch),
    .rsp_last      (rsp_last),
    .lock_active   (lock_active),
    .lock_owner    (lock_owner),
    .abort         (abort)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: XOR with key, one cycle of latency.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid_out <= 1'b0;
      c_data_out  <= 8'h00;
    end else begin
      c_valid_out <= c_valid_in;
      c_data_out  <= c_data_in ^ c_key;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input bit v, input bit s, input bit e,
                       input logic [7:0] k, input logic [7:0] d);
    req_valid[ch]       = v;
    req_sop[ch]         = s;
    req_eop[ch]         = e;
    req_key[ch*8 +: 8]  = k;
    req_data[ch*8 +: 8] = d;
  endtask

  task automatic idle_all();
    for (int c = 0; c < N; c++) drive(c, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic model_reset();
    m_locked = 0; m_abort = 0; m_tag_eop = 0; m_pv = 0;
    m_owner = 0; m_ptr = 0; m_idle = 0; m_tag_ch = 0; m_pout = 8'h00;
  endtask

  // Called one time unit after a rising edge; checks at the falling edge.
  task automatic step();
    int win, ch;
    bit xfer, eop;
    logic [31:0] exp_ready, exp_drive, exp_rsp, exp_stat;
    logic [7:0] k, d;
    #4;
    win = -1;
    if (!m_locked) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (win < 0 && req_valid[c] && req_sop[c]) win = c;
      end
      xfer = (win >= 0);
      ch = xfer ? win : 0;
      exp_ready = xfer ? (32'd1 << win) : 32'd0;
    end else begin
      ch = m_owner;
      xfer = req_valid[ch];
      exp_ready = 32'd1 << ch;
    end
    k = xfer ? req_key[ch*8 +: 8] : 8'h00;
    d = xfer ? req_data[ch*8 +: 8] : 8'h00;
    eop = req_eop[ch];
    exp_drive = {14'd0, xfer, xfer & req_sop[ch], k, d};
    exp_rsp   = {20'd0, m_pv, m_pout, 2'(m_tag_ch), m_tag_eop};
    exp_stat  = {28'd0, m_locked, 2'(m_owner), m_abort};
    check("ready", {28'd0, req_ready}, exp_ready);
    check("cipher_drive", {14'd0, c_valid_in, c_new_message, c_key, c_data_in}, exp_drive);
    check("response", {20'd0, rsp_valid, rsp_data, rsp_ch, rsp_last}, exp_rsp);
    check("status", {28'd0, lock_active, lock_owner, abort}, exp_stat);
    // Advance the model by one clock.
    m_abort = 0;
    if (!m_locked) begin
      if (xfer) begin
        if (eop) m_ptr = (ch + 1) % N;
        else begin m_locked = 1; m_owner = ch; m_idle = 0; end
      end
    end else if (xfer) begin
      m_idle = 0;
      if (eop) begin m_locked = 0; m_ptr = (m_owner + 1) % N; end
    end else begin
      m_idle++;
      if (T != 0 && m_idle == T) begin
        m_locked = 0; m_abort = 1; m_ptr = (m_owner + 1) % N; m_idle = 0;
      end
    end
    if (xfer) begin m_tag_ch = ch; m_tag_eop = eop; end
    m_pv = xfer;
    m_pout = k ^ d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    #4;
    check("reset_drive", {10'd0, req_ready, c_valid_in, c_new_message, c_key, c_data_in}, 32'd0);
    check("reset_status", {16'd0, rsp_valid, rsp_data, rsp_ch, rsp_last, lock_active,
                           lock_owner, abort}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Three-byte message on ch2 with key 0x10.
    drive(2, 1, 1, 0, 8'h10, 8'h00); step();
    drive(2, 1, 0, 0, 8'h10, 8'h00); step();
    drive(2, 1, 0, 1, 8'h10, 8'h00); step();
    idle_all(); step(); step();

    // Simultaneous sop on ch0 and ch1 right after reset.
    do_reset();
    drive(0, 1, 1, 0, 8'hA1, 8'h11); drive(1, 1, 1, 0, 8'hB2, 8'h22); step();
    drive(0, 1, 0, 1, 8'hA1, 8'h12); step();
    drive(0, 0, 0, 0, 8'h00, 8'h00); step();
    drive(1, 1, 0, 0, 8'hB2, 8'h23); step();

    // ch3 tries to cut into ch1's locked message.
    drive(3, 1, 1, 0, 8'hC3, 8'h33); step(); step();
    drive(1, 1, 0, 1, 8'hB2, 8'h24); step();
    drive(1, 0, 0, 0, 8'h00, 8'h00); step();
    drive(3, 1, 0, 1, 8'hC3, 8'h34); step();
    idle_all(); step();

    // Owner stalls until the timeout fires; ch1 waits with sop.
    do_reset();
    drive(0, 1, 1, 0, 8'h5A, 8'h01); step();
    drive(0, 0, 0, 0, 8'h00, 8'h00); drive(1, 1, 1, 0, 8'h6B, 8'h02);
    for (int i = 0; i < T + 1; i++) step();
    drive(1, 1, 0, 1, 8'h6B, 8'h03); step();
    idle_all(); step();

    // Reset in the middle of a ch3 message; later non-sop bytes must stall.
    drive(3, 1, 1, 0, 8'h77, 8'h40); step();
    drive(3, 1, 0, 0, 8'h77, 8'h41); step();
    do_reset();
    drive(3, 1, 0, 0, 8'h77, 8'h42); step(); step(); step();
    drive(3, 1, 0, 1, 8'h77, 8'h43); step();
    idle_all(); step();

    // Single-byte message on ch1, then a three-way contest resolved from ch2.
    drive(1, 1, 1, 1, 8'h99, 8'h55); step();
    idle_all(); step();
    drive(0, 1, 1, 1, 8'h01, 8'h0A); drive(2, 1, 1, 1, 8'h02, 8'h0B);
    drive(3, 1, 1, 1, 8'h03, 8'h0C); step();
    idle_all(); step();

    // Random traffic, busy then sparse so timeouts also occur.
    for (int cyc = 0; cyc < 600; cyc++) begin
      int pv;
      pv = (cyc < 300) ? 80 : 35;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        for (int c = 0; c < N; c++)
          drive(c, $urandom_range(0, 99) < pv, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 30, 8'($urandom), 8'($urandom));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hes_cipher_arbiter.md
HES_CIPHER_ARBITER -- requirements
Module: hes_cipher_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of requester channels (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16: idle cycles before a locked owner is aborted (0 = never).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_CH bits: per-channel byte valid.
REQ-007 The block SHALL have port req_sop, input, NUM_CH bits: byte is first of a message.
REQ-008 The block SHALL have port req_eop, input, NUM_CH bits: byte is last of a message.
REQ-009 The block SHALL have port req_key, input, NUM_CH*8 bits: per-channel key, sampled on sop transfers.
REQ-010 The block SHALL have port req_data, input, NUM_CH*8 bits: per-channel data byte.
REQ-011 The block SHALL have port req_ready, output, NUM_CH bits: byte accepted this cycle when valid and ready are both high.
REQ-012 The block SHALL have port c_valid_in, output, 1 bit; c_new_message, output, 1 bit; c_key, output, 8 bits; c_data_in, output, 8 bits: drive to the cipher.
REQ-013 The block SHALL have port c_valid_out, input, 1 bit; c_data_out, input, 8 bits: return path from the cipher, 1-cycle latency.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit; rsp_data, output, 8 bits; rsp_ch, output, clog2(NUM_CH) bits; rsp_last, output, 1 bit: tagged result.
REQ-015 The block SHALL have port lock_active, output, 1 bit; lock_owner, output, clog2(NUM_CH) bits; abort, output, 1 bit: status, with abort as a 1-cycle pulse.

Function
REQ-016 The FSM SHALL have states IDLE and LOCKED, because the cipher holds one counter and messages must never interleave.
REQ-017 In IDLE, round-robin SHALL select among channels with req_valid&req_sop, with the search starting at rr_ptr; the winner's req_ready is high in the same cycle.
REQ-018 In IDLE, a channel with valid but no sop SHALL NOT be granted (ready=0); that channel stalls.
REQ-019 A transfer SHALL drive c_valid_in=1, c_data_in=owner data and c_key=owner key combinationally; c_new_message equals the owner's req_sop.
REQ-020 With no transfer, c_valid_in, c_new_message, c_key and c_data_in SHALL be 0.
REQ-021 An IDLE transfer without eop SHALL move the FSM to LOCKED with owner=winner; a transfer with sop&eop (1-byte message) SHALL leave it in IDLE with rr_ptr=winner+1 mod NUM_CH.
REQ-022 In LOCKED, req_ready[owner]=1 and all other readies SHALL be 0.
REQ-023 In LOCKED, sop on the owner SHALL restart the message (new_message=1) and keep the lock.
REQ-024 In LOCKED, an eop transfer SHALL return the FSM to IDLE, set rr_ptr=owner+1 mod NUM_CH and clear the idle counter.
REQ-025 The idle counter SHALL increment each LOCKED cycle in which req_valid[owner]=0 and clear on any owner transfer.
REQ-026 When the idle counter reaches TIMEOUT and TIMEOUT is nonzero, the FSM SHALL move to IDLE, pulse abort for 1 cycle and set rr_ptr=owner+1.
REQ-027 The tag pipeline SHALL register {owner, eop} on each transfer; when c_valid_out=1, rsp_valid=1, rsp_data=c_data_out, rsp_ch=the registered owner and rsp_last=the registered eop, all combinational.
REQ-028 The response path SHALL have no backpressure; rsp_valid follows c_valid_out exactly.
REQ-029 lock_active SHALL be 1 exactly in LOCKED, and lock_owner SHALL equal the owner register.

Reset
REQ-030 Reset SHALL force the FSM to IDLE, rr_ptr=0, idle counter=0, tag registers=0, abort=0, lock_active=0 and lock_owner=0.
REQ-031 Reset asserted mid-message SHALL discard the lock; the first post-reset grant requires sop.
REQ-032 The cipher SHALL share the same reset event, inverted to its active-low reset_n at integration.

Structure
REQ-033 Package hes_pkg SHALL hold the arb_state_e typedef (IDLE, LOCKED) and the CH_W = clog2(NUM_CH) helper.
REQ-034 The block SHALL contain sub-module hes_rr_arbiter: combinational round-robin, inputs req vector and rr_ptr, outputs one-hot grant and grant index.

Verification
REQ-035 Ch2 sends sop key=0x10, data 0x00,0x00,0x00 with eop on byte 3 -> c_new_message=1 on byte 1 only, c_key=0x10, three rsp_ch=2 responses one cycle after each transfer, last with rsp_last=1.
REQ-036 Ch0 and ch1 both assert sop at reset exit -> ch0 granted; ch1 ready stays 0 until the cycle after ch0's eop transfer, then ch1 granted.
REQ-037 Ch1 locked; ch3 asserts sop mid-message -> req_ready[3]=0 and no interleaved byte appears on c_data_in.
REQ-038 TIMEOUT=4, ch0 locked, ch0 valid drops -> abort pulses on the 4th idle cycle, FSM in IDLE, next grant goes to ch1 if it is requesting.
REQ-039 Reset asserted for 1 cycle during a ch3 message -> all outputs 0; ch3 non-sop bytes after reset are never granted.
REQ-040 Ch1 sends a 1-byte message (sop&eop) -> lock_active stays 0 and rr_ptr advances to 2.
